// File: rtl/cmp_flag_eval_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
//  Shared definitions for the comparator flag evaluation unit: condition code
//  values, FSM state encoding, flag bit positions and a one-hot helper.
// ---------------------------------------------------------------------------
package cmp_pkg;

    // Condition codes presented on cond_code
    localparam logic [2:0] COND_NEVER  = 3'b000;
    localparam logic [2:0] COND_GT     = 3'b001;
    localparam logic [2:0] COND_EQ     = 3'b010;
    localparam logic [2:0] COND_GE     = 3'b011;
    localparam logic [2:0] COND_LT     = 3'b100;
    localparam logic [2:0] COND_NE     = 3'b101;
    localparam logic [2:0] COND_LE     = 3'b110;
    localparam logic [2:0] COND_ALWAYS = 3'b111;

    // FSM encoding; 2'd3 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bit positions inside the {G,E,L} flag vector
    localparam int FLG_G = 2;
    localparam int FLG_E = 1;
    localparam int FLG_L = 0;

    // True when exactly one of the three comparator flags is set
    function automatic logic is_one_hot3(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

endpackage

// File: rtl/cmp_flag_eval_cond_decode.sv
// ---------------------------------------------------------------------------
// cmp_cond_decode
//  Purely combinational evaluation of a condition code against a latched
//  {G,E,L} flag vector.
//  Ports:
//    i_code   [2:0]  condition code
//    i_flags  [2:0]  flag vector {G,E,L}
//    o_taken         condition holds
// ---------------------------------------------------------------------------
module cmp_cond_decode
    import cmp_pkg::*;
(
    input  logic [2:0] i_code,
    input  logic [2:0] i_flags,
    output logic       o_taken
);

    logic w_g;
    logic w_e;
    logic w_l;

    assign w_g = i_flags[FLG_G];
    assign w_e = i_flags[FLG_E];
    assign w_l = i_flags[FLG_L];

    always_comb begin
        o_taken = 1'b0;
        case (i_code)
            COND_NEVER:  o_taken = 1'b0;
            COND_GT:     o_taken = w_g;
            COND_EQ:     o_taken = w_e;
            COND_GE:     o_taken = w_g | w_e;
            COND_LT:     o_taken = w_l;
            COND_NE:     o_taken = ~w_e;
            COND_LE:     o_taken = w_l | w_e;
            COND_ALWAYS: o_taken = 1'b1;
            default:     o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_flag_eval.sv
// ---------------------------------------------------------------------------
// cmp_flag_eval
//  Sequential condition unit behind the 4-bit comparator. Captures G/E/L into
//  a flag register, accepts a condition request (valid/ready), waits for fresh
//  flags if needed (with timeout), and returns a registered taken/err result
//  (valid/ready).
//  Optional feature macro: CMP_FLAG_STATS_EN adds saturating per-flag capture
//  counters cnt_g/cnt_e/cnt_l.
//  Parameters:
//    TO_W   width of the WAIT timeout counter (timeout after 2**TO_W-1 cycles)
//    CNT_W  width of each statistics counter
//  Ports:
//    clk, rst_n                 clock, asynchronous active-low reset
//    flg_valid, flg_g/e/l       comparator flags and their qualifier
//    cond_valid, cond_ready     request handshake
//    cond_code [2:0]            condition code
//    res_valid, res_ready       result handshake
//    res_taken, res_err         result payload
//    flags_q [2:0]              latched {G,E,L}
//    cnt_g/e/l [CNT_W-1:0]      capture counters (CMP_FLAG_STATS_EN only)
// ---------------------------------------------------------------------------
module cmp_flag_eval
    import cmp_pkg::*;
#(
    parameter int TO_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flg_valid,
    input  logic             flg_g,
    input  logic             flg_e,
    input  logic             flg_l,
    input  logic             cond_valid,
    output logic             cond_ready,
    input  logic [2:0]       cond_code,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic             res_err,
    output logic [2:0]       flags_q
`ifdef CMP_FLAG_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_g,
    output logic [CNT_W-1:0] cnt_e,
    output logic [CNT_W-1:0] cnt_l
`endif
);

    // Last counter value before the timeout fires (2**TO_W-2)
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_code;
    logic [2:0]      r_flags;
    logic            r_fresh;
    logic            r_err;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_nxt;
    logic            r_res_taken;
    logic            r_res_err;

    logic [2:0]      w_flg_vec;
    logic            w_flg_legal;
    logic            w_flg_illegal;
    logic            w_load_code;
    logic            w_timeout;
    logic            w_clr_err;
    logic            w_enter_resp;
    logic [2:0]      w_code_eval;
    logic            w_taken;

    assign w_flg_vec     = {flg_g, flg_e, flg_l};
    assign w_flg_legal   = flg_valid &  is_one_hot3(w_flg_vec);
    assign w_flg_illegal = flg_valid & ~is_one_hot3(w_flg_vec);

    // When accepting straight into RESP the code is not yet latched
    assign w_code_eval = (r_state == ST_IDLE) ? cond_code : r_code;

    cmp_cond_decode u_decode (
        .i_code  (w_code_eval),
        .i_flags (r_flags),
        .o_taken (w_taken)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_to_cnt_nxt = r_to_cnt;
        w_load_code  = 1'b0;
        w_timeout    = 1'b0;
        w_clr_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cond_valid) begin
                    w_load_code = 1'b1;
                    if (r_fresh) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt  = ST_WAIT;
                        w_to_cnt_nxt = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (r_fresh) begin
                    w_state_nxt = ST_RESP;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = ST_RESP;
                    w_timeout   = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_clr_err   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_code      <= COND_NEVER;
            r_flags     <= 3'b000;
            r_fresh     <= 1'b0;
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
            r_res_taken <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_cnt_nxt;
            if (w_load_code) begin
                r_code <= cond_code;
            end
            if (w_flg_legal) begin
                r_flags <= w_flg_vec;
            end
            // New flags landing on the consume edge were not evaluated, keep them fresh
            if (w_flg_legal) begin
                r_fresh <= 1'b1;
            end else if (w_enter_resp) begin
                r_fresh <= 1'b0;
            end
            // Illegal flags in the handoff cycle keep the error sticky
            if (w_flg_illegal) begin
                r_err <= 1'b1;
            end else if (w_clr_err) begin
                r_err <= 1'b0;
            end
            if (w_enter_resp) begin
                r_res_taken <= w_timeout ? 1'b0 : w_taken;
                r_res_err   <= r_err | w_timeout;
            end
        end
    end

    assign cond_ready = (r_state == ST_IDLE);
    assign res_valid  = (r_state == ST_RESP);
    assign res_taken  = r_res_taken;
    assign res_err    = r_res_err;
    assign flags_q    = r_flags;

`ifdef CMP_FLAG_STATS_EN
    logic [CNT_W-1:0] r_cnt_g;
    logic [CNT_W-1:0] r_cnt_e;
    logic [CNT_W-1:0] r_cnt_l;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_g <= '0;
            r_cnt_e <= '0;
            r_cnt_l <= '0;
        end else if (w_flg_legal) begin
            if (flg_g) r_cnt_g <= sat_inc(r_cnt_g);
            if (flg_e) r_cnt_e <= sat_inc(r_cnt_e);
            if (flg_l) r_cnt_l <= sat_inc(r_cnt_l);
        end
    end

    assign cnt_g = r_cnt_g;
    assign cnt_e = r_cnt_e;
    assign cnt_l = r_cnt_l;
`endif

endmodule

// File: tb/tb_cmp_flag_eval.sv
// ---------------------------------------------------------------------------
// tb_cmp_flag_eval
//  Directed bench for cmp_flag_eval (TO_W=4, CNT_W=2). Counter checks are
//  compiled in when CMP_FLAG_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_cmp_flag_eval;

    localparam int TO_W  = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flg_valid = 1'b0;
    logic             flg_g = 1'b0;
    logic             flg_e = 1'b0;
    logic             flg_l = 1'b0;
    logic             cond_valid = 1'b0;
    logic             cond_ready;
    logic [2:0]       cond_code = 3'b000;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             res_taken;
    logic             res_err;
    logic [2:0]       flags_q;
`ifdef CMP_FLAG_STATS_EN
    logic [CNT_W-1:0] cnt_g;
    logic [CNT_W-1:0] cnt_e;
    logic [CNT_W-1:0] cnt_l;
`endif

    int total = 0;
    int bad   = 0;

    cmp_flag_eval #(.TO_W(TO_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flg_valid  (flg_valid),
        .flg_g      (flg_g),
        .flg_e      (flg_e),
        .flg_l      (flg_l),
        .cond_valid (cond_valid),
        .cond_ready (cond_ready),
        .cond_code  (cond_code),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_taken  (res_taken),
        .res_err    (res_err),
        .flags_q    (flags_q)
`ifdef CMP_FLAG_STATS_EN
        ,
        .cnt_g      (cnt_g),
        .cnt_e      (cnt_e),
        .cnt_l      (cnt_l)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_flags(input logic [2:0] v);
        flg_valid = 1'b1;
        {flg_g, flg_e, flg_l} = v;
        tick();
        flg_valid = 1'b0;
        {flg_g, flg_e, flg_l} = 3'b000;
    endtask

    task automatic request(input logic [2:0] code);
        cond_valid = 1'b1;
        cond_code  = code;
        tick();
        cond_valid = 1'b0;
    endtask

    task automatic handoff();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_ready", cond_ready, 1);
        chk("rst_valid", res_valid, 0);
        chk("rst_taken", res_taken, 0);
        chk("rst_err", res_err, 0);
        chk("rst_flags", flags_q, 3'b000);
        rst_n = 1'b1;
        tick();

        // fresh G flags, GT taken one cycle after acceptance
        put_flags(3'b100);
        chk("cap_flags", flags_q, 3'b100);
        request(3'b001);
        chk("gt_valid", res_valid, 1);
        chk("gt_taken", res_taken, 1);
        chk("gt_err", res_err, 0);
        handoff();
        chk("gt_idle_rdy", cond_ready, 1);
        chk("gt_idle_vld", res_valid, 0);
        put_flags(3'b100);
        request(3'b011);
        chk("ge_taken", res_taken, 1);
        handoff();
        put_flags(3'b100);
        request(3'b101);
        chk("ne_taken", res_taken, 1);
        handoff();
        put_flags(3'b100);
        request(3'b110);
        chk("le_valid", res_valid, 1);
        chk("le_taken", res_taken, 0);
        handoff();

        // EQ without fresh flags waits, flags arrive later
        request(3'b010);
        chk("eq_wait_rdy", cond_ready, 0);
        chk("eq_wait_vld", res_valid, 0);
        tick();
        tick();
        put_flags(3'b010);
        chk("eq_fresh_vld", res_valid, 0);
        tick();
        chk("eq_valid", res_valid, 1);
        chk("eq_taken", res_taken, 1);
        chk("eq_err", res_err, 0);
        handoff();

        // illegal flags set sticky err, cleared by handoff
        put_flags(3'b110);
        chk("ill_keep", flags_q, 3'b010);
        put_flags(3'b000);
        put_flags(3'b001);
        request(3'b100);
        chk("lt_taken", res_taken, 1);
        chk("lt_err", res_err, 1);
        handoff();
        put_flags(3'b001);
        request(3'b100);
        chk("lt2_err", res_err, 0);
        chk("lt2_taken", res_taken, 1);
        handoff();

        // timeout: 15 cycles in WAIT then RESP with err
        request(3'b101);
        for (int i = 0; i < 14; i++) tick();
        chk("to_not_yet", res_valid, 0);
        tick();
        chk("to_valid", res_valid, 1);
        chk("to_taken", res_taken, 0);
        chk("to_err", res_err, 1);
        handoff();

        // stalled result stays stable while new flags arrive
        put_flags(3'b100);
        request(3'b001);
        flg_valid = 1'b1;
        {flg_g, flg_e, flg_l} = 3'b001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_vld", res_valid, 1);
            chk("stall_taken", res_taken, 1);
        end
        flg_valid = 1'b0;
        {flg_g, flg_e, flg_l} = 3'b000;
        chk("stall_flags", flags_q, 3'b001);
        handoff();
        request(3'b001);
        chk("next_vld", res_valid, 1);
        chk("next_gt_taken", res_taken, 0);
        handoff();

`ifdef CMP_FLAG_STATS_EN
        // saturating counters
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        chk("cnt_rst", cnt_g, 0);
        tick();
        put_flags(3'b100);
        put_flags(3'b100);
        chk("cnt_g2", cnt_g, 2);
        put_flags(3'b100);
        put_flags(3'b100);
        put_flags(3'b100);
        chk("cnt_g_sat", cnt_g, 3);
        chk("cnt_e0", cnt_e, 0);
        chk("cnt_l0", cnt_l, 0);
        request(3'b001);
        handoff();
`endif

        // asynchronous reset in the middle of WAIT
        request(3'b010);
        tick();
        chk("mid_wait", cond_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdy", cond_ready, 1);
        chk("arst_vld", res_valid, 0);
        chk("arst_taken", res_taken, 0);
        chk("arst_err", res_err, 0);
        chk("arst_flags", flags_q, 3'b000);
`ifdef CMP_FLAG_STATS_EN
        chk("arst_cnt_g", cnt_g, 0);
`endif
        rst_n = 1'b1;
        tick();
        request(3'b111);
        chk("post_rst_wait", res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
